// File: rtl/pipe_stage_latch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_stage_latch
// Purpose  : Generic pipeline stage register carrying PC, control bundle and
//            data payload, with a valid/ready handshake, an optional 2-entry
//            skid buffer, a stall (hold) input and a flush (kill) input.
// Revision : 1.0 - initial release
//
// Parameters:
//   PC_W   - width of the PC field
//   CTRL_W - width of the control bundle
//   DATA_W - width of the data payload
//   SKID   - 1: 2-entry skid buffer, in_ready independent of out_ready
//            0: single register, in_ready looks at out_ready
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept this cycle
//   in_pc      in   upstream PC
//   in_ctrl    in   upstream control bundle
//   in_data    in   upstream payload
//   out_valid  out  entry presented downstream
//   out_ready  in   downstream accepts
//   out_pc     out  presented PC
//   out_ctrl   out  presented control, zero whenever out_valid is low
//   out_data   out  presented payload
//   stall      in   hold stage contents, present a bubble downstream
//   flush      in   drop every held entry at the next edge
//   occupancy  out  number of entries held (0..2)
//   stall_cnt  out  saturating count of edges with stall high
//   flush_cnt  out  saturating count of edges with flush high
//
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN
//   Defined   : stall_cnt / flush_cnt are live 16-bit saturating counters.
//   Undefined : stall_cnt / flush_cnt are tied to zero.
//------------------------------------------------------------------------------
module pipe_stage_latch #(
  parameter int PC_W   = 16,
  parameter int CTRL_W = 8,
  parameter int DATA_W = 48,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  // State encoding equals the number of held entries, so occupancy is the
  // state register itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_main_pc;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;

  logic [PC_W-1:0]   w_skid_pc;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  logic w_main_valid;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_main_valid = (r_state != ST_EMPTY);

  // A stall masks the held entry so downstream sees a bubble.
  assign out_valid  = w_main_valid && !stall;
  assign out_pc     = r_main_pc;
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign out_data   = r_main_data;
  assign occupancy  = r_state;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [PC_W-1:0]   r_skid_pc;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;

      // Ready depends only on registered state, cutting the out_ready path.
      assign in_ready = !stall && (r_state != ST_TWO);

      // The skid slot only fills when the main slot is busy and does not
      // drain on the same edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_skid_pc   <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else if (flush) begin
          r_skid_pc   <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else if ((r_state == ST_ONE) && w_in_xfer && !w_out_xfer) begin
          r_skid_pc   <= in_pc;
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
        end
      end

      assign w_skid_pc   = r_skid_pc;
      assign w_skid_ctrl = r_skid_ctrl;
      assign w_skid_data = r_skid_data;
    end else begin : g_single
      // Without a skid slot the stage can only refill while draining.
      assign in_ready    = !stall && (!w_main_valid || out_ready);
      assign w_skid_pc   = '0;
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
    end
  endgenerate

  // Main slot and occupancy state. In the single-register build the
  // "in only" transition out of ST_ONE can never fire, because in_ready
  // there implies a simultaneous out-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_pc   <= '0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (flush) begin
      // Flush beats stall and discards any same-cycle in-transfer.
      r_state     <= ST_EMPTY;
      r_main_pc   <= '0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_state     <= ST_ONE;
            r_main_pc   <= in_pc;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main_pc   <= in_pc;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_in_xfer) begin
            r_state <= ST_TWO;
          end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            r_state     <= ST_ONE;
            r_main_pc   <= w_skid_pc;
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pipe_stage_latch
// Purpose  : Directed self-checking bench for pipe_stage_latch with a
//            scoreboard queue for the SKID=1 instance and directed checks on
//            a second SKID=0 instance.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pipe_stage_latch;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  ctrl;
    logic [47:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;

  // SKID=1 instance signals
  logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [15:0] in_pc, out_pc, stall_cnt, flush_cnt;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [47:0] in_data, out_data;
  logic [1:0]  occupancy;

  // SKID=0 instance signals
  logic        in_valid0, in_ready0, out_valid0, out_ready0, stall0, flush0;
  logic [15:0] in_pc0, out_pc0, stall_cnt0, flush_cnt0;
  logic [7:0]  in_ctrl0, out_ctrl0;
  logic [47:0] in_data0, out_data0;
  logic [1:0]  occupancy0;

  ent_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_latch #(.PC_W(16), .CTRL_W(8), .DATA_W(48), .SKID(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall(stall), .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_latch #(.PC_W(16), .CTRL_W(8), .DATA_W(48), .SKID(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_pc(in_pc0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_pc(out_pc0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .stall(stall0), .flush(flush0), .occupancy(occupancy0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one entry on the SKID=1 input side.
  task automatic drive(input logic v, input logic [15:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = 8'h5A;
    in_data  = {32'hA5A5_0000, pc};
  endtask

  // Sample point: scoreboard pops on out-transfers, pushes on accepted
  // in-transfers, and a flush empties everything not delivered this cycle.
  task automatic mid();
    ent_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_out", 80'(q.size()), 80'd1);
      end else begin
        e = q.pop_front();
        chk("sb_pc",   80'(out_pc),   80'(e.pc));
        chk("sb_ctrl", 80'(out_ctrl), 80'(e.ctrl));
        chk("sb_data", 80'(out_data), 80'(e.data));
      end
    end
    if (in_valid && in_ready && !flush) begin
      e.pc   = in_pc;
      e.ctrl = in_ctrl;
      e.data = in_data;
      q.push_back(e);
    end
    if (flush) q.delete();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0000);
    out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid0 = 1'b0; in_pc0 = '0; in_ctrl0 = '0; in_data0 = '0;
    out_ready0 = 1'b0; stall0 = 1'b0; flush0 = 1'b0;

    // Reset state
    #2;
    chk("rst_occ",       80'(occupancy), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_ctrl",  80'(out_ctrl),  80'd0);
    chk("rst_out_pc",    80'(out_pc),    80'd0);
    chk("rst_out_data",  80'(out_data),  80'd0);
    chk("rst_in_ready",  80'(in_ready),  80'd1);
    chk("rst_stall_cnt", 80'(stall_cnt), 80'd0);
    stall = 1'b1;
    #1;
    chk("rst_in_ready_stall", 80'(in_ready), 80'd0);
    stall = 1'b0;
    edge_step();
    reset = 1'b0;

    // Streaming, out_ready=1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i));
      mid();
      chk("stream_in_ready", 80'(in_ready),  80'd1);
      chk("stream_occ",      80'(occupancy), (i == 0) ? 80'd0 : 80'd1);
      chk("stream_valid",    80'(out_valid), (i == 0) ? 80'd0 : 80'd1);
      if (i > 0) chk("stream_pc", 80'(out_pc), 80'(i - 1));
      edge_step();
    end
    drive(1'b0, 16'h0000);
    mid();
    chk("stream_last_pc", 80'(out_pc), 80'h3);
    edge_step();
    mid();
    chk("stream_drained_occ",   80'(occupancy), 80'd0);
    chk("stream_drained_valid", 80'(out_valid), 80'd0);
    chk("stream_drained_ctrl",  80'(out_ctrl),  80'd0);
    edge_step();

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0010);
    mid(); edge_step();
    drive(1'b1, 16'h0011);
    mid();
    chk("bp_in_ready_one", 80'(in_ready), 80'd1);
    edge_step();
    drive(1'b0, 16'h0000);
    mid();
    chk("bp_occ2",      80'(occupancy), 80'd2);
    chk("bp_in_ready0", 80'(in_ready),  80'd0);
    chk("bp_hold_pc",   80'(out_pc),    80'h10);
    chk("bp_valid",     80'(out_valid), 80'd1);
    edge_step();
    mid();
    chk("bp_hold_pc2",  80'(out_pc),    80'h10);
    edge_step();
    out_ready = 1'b1;
    mid();
    chk("bp_first_pc",        80'(out_pc),   80'h10);
    chk("bp_in_ready_before", 80'(in_ready), 80'd0);
    edge_step();
    mid();
    chk("bp_in_ready_after", 80'(in_ready),  80'd1);
    chk("bp_second_pc",      80'(out_pc),    80'h11);
    chk("bp_occ1",           80'(occupancy), 80'd1);
    edge_step();

    // Stall for 3 cycles with an entry held and upstream still offering
    drive(1'b1, 16'h0020);
    mid(); edge_step();
    drive(1'b1, 16'h0021);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall_valid",    80'(out_valid), 80'd0);
      chk("stall_ctrl",     80'(out_ctrl),  80'd0);
      chk("stall_in_ready", 80'(in_ready),  80'd0);
      edge_step();
    end
    stall = 1'b0;
    drive(1'b0, 16'h0000);
    mid();
    chk("stall_rel_valid", 80'(out_valid), 80'd1);
    chk("stall_rel_pc",    80'(out_pc),    80'h20);
    chk("stall_rel_ctrl",  80'(out_ctrl),  80'h5A);
    chk("stall_rel_occ",   80'(occupancy), 80'd1);
    chk("stall_cnt3",      80'(stall_cnt), PERF ? 80'd3 : 80'd0);
    edge_step();

    // Flush with a full buffer and an offered entry
    out_ready = 1'b0;
    drive(1'b1, 16'h0030);
    mid(); edge_step();
    drive(1'b1, 16'h0031);
    mid(); edge_step();
    drive(1'b1, 16'h0032);
    flush = 1'b1;
    mid(); edge_step();
    flush = 1'b0;
    drive(1'b0, 16'h0000);
    out_ready = 1'b1;
    mid();
    chk("flush_occ",   80'(occupancy), 80'd0);
    chk("flush_valid", 80'(out_valid), 80'd0);
    chk("flush_ctrl",  80'(out_ctrl),  80'd0);
    chk("flush_cnt1",  80'(flush_cnt), PERF ? 80'd1 : 80'd0);
    edge_step();
    mid();
    chk("flush_no_0x32", 80'(out_valid), 80'd0);
    edge_step();

    // Flush with one entry delivered on the same edge, input discarded
    drive(1'b1, 16'h0033);
    mid(); edge_step();
    drive(1'b1, 16'h0034);
    flush = 1'b1;
    mid(); edge_step();
    flush = 1'b0;
    drive(1'b0, 16'h0000);
    mid();
    chk("flush1_valid", 80'(out_valid), 80'd0);
    chk("flush1_occ",   80'(occupancy), 80'd0);
    chk("flush_cnt2",   80'(flush_cnt), PERF ? 80'd2 : 80'd0);
    edge_step();

    // Flush and stall together
    drive(1'b1, 16'h0050);
    mid(); edge_step();
    drive(1'b0, 16'h0000);
    stall = 1'b1; flush = 1'b1;
    mid();
    chk("fs_valid", 80'(out_valid), 80'd0);
    edge_step();
    stall = 1'b0; flush = 1'b0;
    mid();
    chk("fs_occ",       80'(occupancy), 80'd0);
    chk("fs_valid_after", 80'(out_valid), 80'd0);
    chk("fs_stall_cnt", 80'(stall_cnt), PERF ? 80'd4 : 80'd0);
    chk("fs_flush_cnt", 80'(flush_cnt), PERF ? 80'd3 : 80'd0);
    edge_step();

    // Asynchronous reset pulse between edges
    out_ready = 1'b0;
    drive(1'b1, 16'h0060);
    mid(); edge_step();
    drive(1'b0, 16'h0000);
    chk("ar_valid_before", 80'(out_valid), 80'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid",     80'(out_valid), 80'd0);
    chk("ar_occ",       80'(occupancy), 80'd0);
    chk("ar_stall_cnt", 80'(stall_cnt), 80'd0);
    chk("ar_flush_cnt", 80'(flush_cnt), 80'd0);
    q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h0061);
    mid(); edge_step();
    drive(1'b0, 16'h0000);
    mid();
    chk("ar_first_pc",    80'(out_pc),    80'h61);
    chk("ar_first_valid", 80'(out_valid), 80'd1);
    edge_step();

    // SKID=0 instance
    in_valid0 = 1'b1; in_pc0 = 16'h0040; in_ctrl0 = 8'h3C; in_data0 = 48'h40;
    @(negedge clk);
    chk("s0_in_ready_empty", 80'(in_ready0), 80'd1);
    edge_step();
    in_pc0 = 16'h0041; in_data0 = 48'h41;
    @(negedge clk);
    chk("s0_in_ready_held", 80'(in_ready0),  80'd0);
    chk("s0_hold_pc",       80'(out_pc0),    80'h40);
    chk("s0_occ1",          80'(occupancy0), 80'd1);
    chk("s0_valid",         80'(out_valid0), 80'd1);
    edge_step();
    @(negedge clk);
    chk("s0_hold_pc2", 80'(out_pc0), 80'h40);
    out_ready0 = 1'b1;
    #1;
    chk("s0_in_ready_drain", 80'(in_ready0), 80'd1);
    edge_step();
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("s0_replaced_pc",   80'(out_pc0),   80'h41);
    chk("s0_replaced_data", 80'(out_data0), 80'h41);
    chk("s0_replaced_ctrl", 80'(out_ctrl0), 80'h3C);
    edge_step();
    @(negedge clk);
    chk("s0_empty_occ",  80'(occupancy0), 80'd0);
    chk("s0_empty_ctrl", 80'(out_ctrl0),  80'd0);

    chk("sb_drain", 80'(q.size()), 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Parametrised successor to the fixed-field pipeline latches: one generic stage register carrying PC, control bundle and data payload.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, and a stall (hold) input.
- Adds a flush (kill) input that turns the stage into a bubble with zeroed control.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/M, M/WB).

Parameters:
PC_W, 16, width of PC field (matches WORD_SIZE)
CTRL_W, 8, width of control bundle (WB/M/EX signals concatenated)
DATA_W, 48, width of data payload (operands, immediates, reg index)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_pc  in  PC_W  upstream PC
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream payload
out_valid  out  1  entry presented downstream
out_ready  in  1  downstream accepts
out_pc  out  PC_W  presented PC
out_ctrl  out  CTRL_W  presented control; forced 0 when out_valid=0
out_data  out  DATA_W  presented payload
stall  in  1  hazard hold: freeze stage contents
flush  in  1  kill all held entries (branch/jump flush)
occupancy  out  2  entries held (0..2)
stall_cnt  out  16  stall cycles (optional feature)
flush_cnt  out  16  flush events (optional feature)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset: all entry registers 0, state EMPTY, occupancy 0, out_valid 0, out_ctrl/out_pc/out_data 0, counters 0.
  - in_ready = !stall during reset.
- Transfers: in-transfer = in_valid && in_ready; out-transfer = out_valid && out_ready. Latency in-to-out is 1 cycle.
- SKID=1 state machine:
  - EMPTY:
    - in-transfer -> ONE (main <= input).
  - ONE:
    - in and out -> ONE (main <= input).
    - in only -> TWO (skid <= input).
    - out only -> EMPTY.
    - neither -> ONE.
  - TWO:
    - in_ready = 0.
    - out-transfer -> ONE (main <= skid).
  - in_ready = !stall && state != TWO. No combinational path from out_ready to in_ready.
- SKID=0: single main register.
  - in_ready = !stall && (!main_valid || out_ready).
  - occupancy is 0 or 1.
- Output ordering and stability:
  - Outputs always show the main entry; FIFO order is preserved.
  - While out_valid && !out_ready, out_pc/out_ctrl/out_data are stable.
- stall=1:
  - in_ready = 0 and out_valid = 0; no transfers occur.
  - State and entries are held; out_ctrl = 0 (bubble to downstream).
- flush=1 (synchronous, next edge):
  - Every valid entry is dropped; state -> EMPTY; entry registers zeroed.
  - Any same-cycle in-transfer is discarded.
  - A same-cycle out-transfer still counts as delivered downstream.
- flush and stall together: flush wins; state -> EMPTY.
- Reset asserted mid-operation: contents lost immediately (asynchronous).
  - The first in-transfer is accepted on the first edge after deassertion.
- Payload passes through unmodified; no width conversion.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - stall_cnt += 1 on every clock edge with stall=1.
  - flush_cnt += 1 on every edge with flush=1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear only on reset.
- Undefined: stall_cnt and flush_cnt ports tied to 0; no counter flops synthesised.

Test Plan:
- Reset then stream (SKID=1, out_ready=1):
  - Stimulus: PC 0x0000..0x0003 with ctrl 0x5A, one per cycle.
  - Required: each appears on out_* exactly 1 cycle later, in order; occupancy stays 1; in_ready stays 1.
- Backpressure (SKID=1):
  - Stimulus: out_ready=0, send PC 0x0010 and 0x0011.
  - Required: occupancy=2 and in_ready=0 after the 2nd edge; out_pc holds 0x0010.
  - Then raise out_ready: 0x0010 then 0x0011 are delivered; in_ready=1 one edge after the first delivery.
- Stall:
  - Stimulus: stall=1 for 3 cycles with PC 0x0020 held.
  - Required: out_valid=0, out_ctrl=0, in_ready=0 throughout.
  - After release, 0x0020 is presented unchanged; stall_cnt=3 with the macro, 0 without.
- Flush with full buffer:
  - Stimulus: occupancy=2 (PCs 0x0030, 0x0031), flush=1 with in_valid=1 (PC 0x0032).
  - Required: next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x0032 is never emitted; flush_cnt=1 with the macro.
- Flush+stall and async reset:
  - flush=stall=1 -> required: EMPTY next cycle.
  - Reset pulse between edges while occupancy=1 -> required: out_valid drops to 0 before the next edge.
- SKID=0 build:
  - Stimulus: out_ready=0, PC 0x0040 loaded.
  - Required: in_ready=0 while the entry is held.
  - With out_ready=1 and in_valid=1, in_ready=1 the same cycle and 0x0041 replaces 0x0040 at the edge.
